// File: rtl/bomb_pkg.sv
// ---------------------------------------------------------------------------
// bomb_pkg
// Shared definitions for the bomb game blocks.
//   game_state_e  : game-wide state encoding carried on current_state buses
//   DIGIT_W       : width of one decimal code digit
//   pick_state_e  : internal FSM encoding of rnd_code_picker
// ---------------------------------------------------------------------------
package bomb_pkg;

   localparam int DIGIT_W      = 4;
   localparam int GAME_STATE_W = 3;

   typedef enum logic [GAME_STATE_W-1:0] {
      IDLE              = 3'd0,
      ATIVATING         = 3'd1,
      ATIVATED          = 3'd2,
      DETONATING        = 3'd3,
      MISSION_FAILED    = 3'd4,
      MISSION_SUCCESSED = 3'd5
   } game_state_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_FILL = 2'd2
   } pick_state_e;

endpackage

// File: rtl/rnd_digit_filter.sv
// ---------------------------------------------------------------------------
// rnd_digit_filter
// Combinational digit checker shared by the draw and fill phases of
// rnd_code_picker.
//   nibble       in  candidate digit (raw LFSR nibble)
//   code         in  code assembled so far, digit i at [4i+3:4i]
//   idx          in  number of digits already accepted
//   accept       out candidate is in range and (if UNIQUE) not a repeat
//   first_unused out smallest legal value not yet in the code (0 if !UNIQUE)
// ---------------------------------------------------------------------------
module rnd_digit_filter
   import bomb_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int DIGIT_MAX = 9,
   parameter int UNIQUE    = 1,
   parameter int IDX_W     = 3
) (
   input  logic [DIGIT_W-1:0]        nibble,
   input  logic [DIGITS*DIGIT_W-1:0] code,
   input  logic [IDX_W-1:0]          idx,
   output logic                      accept,
   output logic [DIGIT_W-1:0]        first_unused
);

   logic [DIGITS-1:0] filled;    // slot holds an accepted digit
   logic [DIGITS-1:0] dup_hit;   // slot matches the candidate
   logic [DIGIT_MAX:0] used;     // value already present in the code
   logic               found;

   // Slots at or beyond idx still hold the cleared value 0, so they must be
   // masked out or a legal 0 would look like a duplicate.
   for (genvar g = 0; g < DIGITS; g++) begin : g_slot
      assign filled[g]  = idx > IDX_W'(g);
      assign dup_hit[g] = filled[g] && (code[g*DIGIT_W +: DIGIT_W] == nibble);
   end

   always_comb begin
      used = '0;
      for (int v = 0; v <= DIGIT_MAX; v++) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (filled[i] && (code[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(v)))
               used[v] = 1'b1;
         end
      end
   end

   // Lowest-value priority pick over the unused set.
   always_comb begin
      first_unused = '0;
      found        = 1'b0;
      if (UNIQUE != 0) begin
         for (int v = 0; v <= DIGIT_MAX; v++) begin
            if (!found && !used[v]) begin
               first_unused = DIGIT_W'(v);
               found        = 1'b1;
            end
         end
      end
   end

   assign accept = (nibble <= DIGIT_W'(DIGIT_MAX)) &&
                   ((UNIQUE == 0) || (dup_hit == '0));

endmodule

// File: rtl/rnd_code_picker.sv
// ---------------------------------------------------------------------------
// rnd_code_picker
// Builds a DIGITS-long decimal defuse code from the LFSR word by rejection
// sampling one nibble every four cycles. If MAX_SAMPLES draws do not finish
// the code, the remaining digits are filled deterministically, one per cycle.
//   clk, rst       clock, synchronous active-high reset
//   current_state  game state; IDLE aborts a draw in progress
//   rnd            LFSR word, low nibble is sampled
//   gen_req        single-cycle request for a new code
//   busy           draw or fill in progress
//   code           digit i at [4i+3:4i], digit 0 drawn first
//   code_valid     code complete and stable
//   fallback       at least one digit came from the fill
// ---------------------------------------------------------------------------
module rnd_code_picker
   import bomb_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DIGIT_MAX   = 9,
   parameter int UNIQUE      = 1,
   parameter int MAX_SAMPLES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [GAME_STATE_W-1:0]     current_state,
   input  logic [31:0]                 rnd,
   input  logic                        gen_req,
   output logic                        busy,
   output logic [DIGITS*DIGIT_W-1:0]   code,
   output logic                        code_valid,
   output logic                        fallback
);

   localparam int IDX_W = $clog2(DIGITS + 1);
   localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

   // Parameter sanity: a unique code needs enough distinct digit values.
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("rnd_code_picker: DIGITS must be in 1..8");
   end
   if (DIGIT_MAX > 15 || DIGIT_MAX < 0) begin : g_bad_digit_max
      $error("rnd_code_picker: DIGIT_MAX must fit in one nibble");
   end
   if (UNIQUE != 0 && DIGIT_MAX + 1 < DIGITS) begin : g_bad_unique
      $error("rnd_code_picker: not enough distinct digits for UNIQUE code");
   end
   if (MAX_SAMPLES < 1) begin : g_bad_samples
      $error("rnd_code_picker: MAX_SAMPLES must be at least 1");
   end

   pick_state_e                state_q, state_d;
   logic [DIGITS*DIGIT_W-1:0]  code_q, code_d;
   logic                       valid_q, valid_d;
   logic                       fb_q, fb_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [1:0]                 phase_q, phase_d;

   logic                       req_ok;
   logic                       abort;
   logic                       sample_now;
   logic                       last_digit;
   logic                       sample_limit;
   logic                       filt_accept;
   logic [DIGIT_W-1:0]         filt_first_unused;
   logic                       wr_en;
   logic [DIGIT_W-1:0]         wr_digit;

   // Only the low nibble is consumed; four LFSR shifts refresh it.
   logic unused_rnd;
   assign unused_rnd = ^rnd[31:DIGIT_W];

   assign req_ok       = (state_q == S_IDLE) && gen_req &&
                         (current_state != GAME_STATE_W'(IDLE));
   assign abort        = (state_q != S_IDLE) &&
                         (current_state == GAME_STATE_W'(IDLE));
   assign sample_now   = (state_q == S_DRAW) && (phase_q == 2'd3);
   assign last_digit   = (idx_q == IDX_W'(DIGITS - 1));
   // cnt_q counts samples already taken, so this flags the final one.
   assign sample_limit = (cnt_q == CNT_W'(MAX_SAMPLES - 1));

   rnd_digit_filter #(
      .DIGITS    (DIGITS),
      .DIGIT_MAX (DIGIT_MAX),
      .UNIQUE    (UNIQUE),
      .IDX_W     (IDX_W)
   ) u_filter (
      .nibble       (rnd[DIGIT_W-1:0]),
      .code         (code_q),
      .idx          (idx_q),
      .accept       (filt_accept),
      .first_unused (filt_first_unused)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_ok) state_d = S_DRAW;
         S_DRAW: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (sample_now) begin
               // A digit landing on the final sample still completes normally.
               if (filt_accept && last_digit) state_d = S_IDLE;
               else if (sample_limit)         state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (abort || last_digit) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy       = (state_q != S_IDLE);
      code       = code_q;
      code_valid = valid_q;
      fallback   = fb_q;
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      code_d   = code_q;
      valid_d  = valid_q;
      fb_d     = fb_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      wr_en    = 1'b0;
      wr_digit = filt_first_unused;

      case (state_q)
         S_IDLE: begin
            if (req_ok) begin
               code_d  = '0;
               valid_d = 1'b0;
               fb_d    = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               phase_d = '0;
            end
         end
         S_DRAW: begin
            if (abort) begin
               code_d  = '0;
               valid_d = 1'b0;
               fb_d    = 1'b0;
            end else begin
               phase_d = phase_q + 2'd1;
               if (sample_now) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (filt_accept) begin
                     wr_en    = 1'b1;
                     wr_digit = rnd[DIGIT_W-1:0];
                     if (last_digit) valid_d = 1'b1;
                  end
               end
            end
         end
         S_FILL: begin
            if (abort) begin
               code_d  = '0;
               valid_d = 1'b0;
               fb_d    = 1'b0;
            end else begin
               wr_en = 1'b1;
               fb_d  = 1'b1;
               if (last_digit) valid_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (wr_en) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) code_d[i*DIGIT_W +: DIGIT_W] = wr_digit;
         end
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         code_q  <= '0;
         valid_q <= 1'b0;
         fb_q    <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         phase_q <= '0;
      end else begin
         code_q  <= code_d;
         valid_q <= valid_d;
         fb_q    <= fb_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: doc/rnd_code_picker.md
# rnd_code_picker

Draws a multi-digit decimal defuse code from the 32-bit LFSR word produced by the design's random-number generator and presents it to the game logic with a valid flag. It sits directly downstream of the LFSR, consumes its `rnd` bus, and uses rejection sampling to keep digits uniform and, optionally, distinct. If random draws repeatedly fail, a bounded timeout fills the remaining digits deterministically, so the code is always produced in finite time.

## Interface
- `DIGITS`, 4, number of code digits (1..8).
- `DIGIT_MAX`, 9, largest legal digit value (nibble accepted if ≤ DIGIT_MAX).
- `UNIQUE`, 1, 1 = reject digits already present in the code.
- `MAX_SAMPLES`, 64, sample budget before fallback fill.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `current_state`  in  3  game state, shared encoding: IDLE=0, ATIVATING=1, ATIVATED=2, DETONATING=3, MISSION_FAILED=4, MISSION_SUCCESSED=5.
- `rnd`  in  32  LFSR word; shifts one bit per cycle outside IDLE.
- `gen_req`  in  1  single-cycle request for a new code.
- `busy`  out  1  draw in progress.
- `code`  out  4*DIGITS  digit i in `code[4i+3:4i]`; digit 0 is the first drawn.
- `code_valid`  out  1  `code` is complete and stable.
- `fallback`  out  1  at least one digit came from the fallback fill.

## Operation
- FSM states: S_IDLE, S_DRAW, S_FILL.
- S_IDLE: a request is accepted when `gen_req`=1, `current_state`≠IDLE, and the FSM is in S_IDLE. On acceptance: clear `code`, `code_valid`, `fallback`, the digit index, the sample count, and the 2-bit phase; go to S_DRAW.
- S_DRAW: the phase increments every cycle. On phase==3, sample `rnd[3:0]`; four LFSR shifts give a fresh nibble. Sample count +1.
  - Accept the nibble if it is ≤ DIGIT_MAX and either UNIQUE=0 or the nibble is not among the digits already accepted. On accept, write it at the digit index and increment the index.
  - Last digit accepted → `code_valid`=1, go to S_IDLE.
  - Sample count reaches MAX_SAMPLES with digits missing → S_FILL.
- S_FILL: one digit per cycle. Each is the smallest value 0..DIGIT_MAX not yet used (0 if UNIQUE=0). Set `fallback`=1. After the last digit, assert `code_valid` and go to S_IDLE.
- `busy`=1 exactly in S_DRAW and S_FILL.
- Abort: `current_state`==IDLE while busy → return to S_IDLE with `code_valid`=0 and `code` cleared. The abort takes priority over a same-cycle sample or fill.
- `code` and `code_valid` hold until the next accepted request, an abort, or reset.
- Ignored: `gen_req` while busy, and `gen_req` while `current_state`==IDLE. A request while `code_valid`=1 is accepted, and `code_valid` drops on the following edge.
- Elaboration error if UNIQUE=1 and DIGIT_MAX+1 < DIGITS, or DIGIT_MAX > 15.

## Timing
- Reset values: `code`=0, `code_valid`=0, `busy`=0, `fallback`=0, FSM=S_IDLE.
- `busy` rises on the edge that samples the accepted `gen_req`.
- Sample k (k=1,2,…) is taken on the 4k-th edge after acceptance.
- Best case: `code_valid` rises on the 4·DIGITS-th edge after acceptance (16 for the defaults).
- Worst case: 4·MAX_SAMPLES + DIGITS edges after acceptance.
- `code_valid` and `busy` change on the same edge.

## Structure
- Shared package `bomb_pkg`: game-state encodings (IDLE..MISSION_SUCCESSED) and `DIGIT_W`=4.
- Sub-module `rnd_digit_filter`: combinational. Inputs are the nibble, the current code, the digit index, and the parameters. Outputs are `accept` and `first_unused`, used by both S_DRAW and S_FILL.

## Test plan
- UNIQUE=0, state=1, `rnd` held at 32'h3, pulse `gen_req` → `code_valid` on edge 16, `code`=16'h3333, `fallback`=0.
- UNIQUE=1, state=1, bench supplies nibbles B,7,7,2,F,0,5 at the sample points → `code`=16'h5027 on edge 28.
- UNIQUE=1, `rnd` held at 32'h3 → after 64 samples, fill 0,1,2; `code`=16'h2103 and `fallback`=1 on edge 259.
- Mid-draw (edge 6), drive `current_state`=0 → next edge `busy`=0, `code_valid`=0, `code`=0. A `gen_req` while state=0 is ignored.
- Assert `rst` on edge 10 of a draw → all outputs at reset values next edge. A `gen_req` pulsed while busy has no effect on sample timing.
